if_fetch_unit: RTL and testbench

Instruction Fetch stage for the RV32I 5-stage pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues one-outstanding-request fetches on a valid/ready instruction-memory interface. It presents fetched instruction/PC/PC+4 to IF/ID with a valid flag, honours hazard-unit stalls, and discards wrong-path fetches on branch/jump redirect.

---
 rtl/if_fetch_unit.sv | 91 +++++++++
 tb/tb_if_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32I instruction fetch stage, one outstanding imem request,
// presents instruction/PC/PC+4 to IF/ID and drops wrong-path responses on redirect.
module if_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_instruction,
    output logic [ADDR_WIDTH-1:0] if_PC,
    output logic [ADDR_WIDTH-1:0] if_PC_plus_4
);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_e;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, buf_pc_q, buf_pc_d, target;
    logic [DATA_WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic                  valid_q, valid_d, consume;
    assign target  = redirect_target & ~ADDR_WIDTH'(3);
    assign consume = valid_q & ~stall;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            buf_pc_q    <= RESET_PC;
            buf_instr_q <= NOP;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            valid_q     <= valid_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        valid_d     = valid_q;
        case (state_q)
            S_FETCH: begin
                if (redirect_valid) pc_d = target;
                else if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid && !redirect_valid) begin
                    buf_instr_d = imem_rsp_data;
                    buf_pc_d    = pc_q;
                    valid_d     = 1'b1;
                    pc_d        = pc_q + ADDR_WIDTH'(4);
                    state_d     = S_HOLD;
                end else if (redirect_valid) begin
                    pc_d    = target;
                    state_d = imem_rsp_valid ? S_FETCH : S_DRAIN;
                end
            end
            S_DRAIN: begin
                // the pending response belongs to the old path and is always dropped
                if (redirect_valid) pc_d = target;
                if (imem_rsp_valid) state_d = S_FETCH;
            end
            S_HOLD: begin
                if (redirect_valid || consume) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
                if (redirect_valid) pc_d = target;
            end
        endcase
    end
    always_comb begin
        imem_req_valid = (state_q == S_FETCH) && !redirect_valid;
        imem_req_addr  = pc_q;
        if_valid       = valid_q;
        if_instruction = valid_q ? buf_instr_q : NOP;
        if_PC          = buf_pc_q;
        if_PC_plus_4   = buf_pc_q + ADDR_WIDTH'(4);
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed timing/wrap checks on a high-RESET_PC instance, then
// randomized memory/stall/redirect traffic against a transaction-level fetch model.
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, stall = 1'b0, redirect_valid = 1'b0, imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0, imem_req_valid, if_valid;
    logic [31:0] redirect_target = '0, imem_rsp_data = '0, imem_req_addr;
    logic [31:0] if_instruction, if_PC, if_PC_plus_4;

    logic        rst1_n = 1'b0, ready1 = 1'b1, rsp1_valid = 1'b0, req1_valid, if_valid1;
    logic [31:0] rsp1_data = '0, req1_addr, if_instr1, if_pc1, if_pc4_1;

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .if_valid(if_valid),
        .if_instruction(if_instruction), .if_PC(if_PC), .if_PC_plus_4(if_PC_plus_4)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk(clk), .rst_n(rst1_n), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .imem_req_valid(req1_valid), .imem_req_ready(ready1),
        .imem_req_addr(req1_addr), .imem_rsp_valid(rsp1_valid),
        .imem_rsp_data(rsp1_data), .if_valid(if_valid1),
        .if_instruction(if_instr1), .if_PC(if_pc1), .if_PC_plus_4(if_pc4_1)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    // reference model state: fetch path PC, presented item, and the memory's own view
    logic        m_shown, m_doom, mem_pend, do_rst, prev_rst, fire, genuine, consume, m_req;
    logic [31:0] m_pc, m_spc, m_sins, mem_addr, rsp_d;
    int          mem_cnt;
    logic [31:0] vpc [3];
    logic [31:0] rpc [4];
    logic        fp;
    logic [31:0] ap;
    int          kv, kr;

    initial begin
        vpc = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        rpc = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst1_n = 1'b1;
        #1;
        chk("hi_reset_pc", if_pc1, 32'hFFFF_FFFC);
        chk("hi_reset_pc4", if_pc4_1, 32'h0);
        fp = 1'b0; ap = '0; kv = 0; kr = 0;
        for (int c = 0; c < 10; c++) begin
            rsp1_valid = fp;
            rsp1_data  = ~ap;
            #1;
            chk("hi_valid", {31'b0, if_valid1}, {31'b0, c == 2 || c == 5 || c == 8});
            if (c == 2 || c == 5 || c == 8) begin
                chk("hi_pc", if_pc1, vpc[kv]);
                chk("hi_pc4", if_pc4_1, vpc[kv] + 32'd4);
                chk("hi_instr", if_instr1, ~vpc[kv]);
                kv++;
            end else chk("hi_nop", if_instr1, NOP);
            chk("hi_req", {31'b0, req1_valid}, {31'b0, c % 3 == 0});
            if (c % 3 == 0) begin
                chk("hi_addr", req1_addr, rpc[kr]);
                kr++;
            end
            fp = req1_valid;
            ap = req1_addr;
            @(negedge clk);
        end
        // request to 0x8 is outstanding here: reset mid-request
        rst1_n = 1'b0;
        rsp1_valid = 1'b1;
        rsp1_data = 32'h1111_2222;
        @(negedge clk);
        rst1_n = 1'b1;
        ready1 = 1'b0;
        rsp1_data = 32'hBAD0_0BAD;
        #1;
        chk("hi_rst_valid", {31'b0, if_valid1}, 32'd0);
        chk("hi_rst_nop", if_instr1, NOP);
        chk("hi_rst_req", {31'b0, req1_valid}, 32'd1);
        chk("hi_rst_addr", req1_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        rsp1_valid = 1'b0;
        #1;
        chk("hi_stale_valid", {31'b0, if_valid1}, 32'd0);
        chk("hi_stale_addr", req1_addr, 32'hFFFF_FFFC);

        m_shown = 0; m_doom = 0; mem_pend = 0; mem_cnt = 0; prev_rst = 0;
        m_pc = 0; m_spc = 0; m_sins = 0; mem_addr = 0; rsp_d = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("if_valid", {31'b0, if_valid}, {31'b0, m_shown});
                chk("if_instr", if_instruction, m_shown ? m_sins : NOP);
                if (m_shown || prev_rst) begin
                    chk("if_pc", if_PC, m_spc);
                    chk("if_pc4", if_PC_plus_4, m_spc + 32'd4);
                end
            end
            do_rst = (i < 2) || ($urandom_range(0, 199) == 0);
            rst_n = !do_rst;
            stall = $urandom_range(0, 9) < 3;
            redirect_valid = !do_rst && ($urandom_range(0, 9) == 0);
            redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            imem_req_ready = $urandom_range(0, 9) < 6;
            if (mem_pend) imem_rsp_valid = (mem_cnt == 0);
            else imem_rsp_valid = ($urandom_range(0, 7) == 0);
            imem_rsp_data = $urandom;
            rsp_d = imem_rsp_data;
            #1;
            m_req = !mem_pend && !m_shown && !redirect_valid;
            if (!do_rst) begin
                chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req});
                if (m_req) chk("req_addr", imem_req_addr, m_pc);
            end
            fire = !do_rst && imem_req_valid && imem_req_ready;
            @(posedge clk);
            prev_rst = do_rst;
            if (do_rst) begin
                m_shown = 0; m_doom = 0; mem_pend = 0;
                m_pc = 0; m_spc = 0;
            end else begin
                genuine = mem_pend && imem_rsp_valid;
                consume = m_shown && !stall;
                if (redirect_valid) begin
                    m_pc = redirect_target & ~32'd3;
                    m_shown = 0;
                    if (mem_pend && !genuine) m_doom = 1;
                end else if (genuine) begin
                    if (!m_doom) begin
                        m_shown = 1;
                        m_spc = m_pc;
                        m_sins = rsp_d;
                        m_pc = m_pc + 32'd4;
                    end
                end else if (consume) m_shown = 0;
                if (genuine) begin
                    mem_pend = 0;
                    m_doom = 0;
                end
                if (mem_pend && mem_cnt > 0) mem_cnt--;
                if (fire) begin
                    mem_pend = 1;
                    mem_cnt = $urandom_range(0, 3);
                    mem_addr = imem_req_addr;
                end
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
